// File: rtl/sample_serializer_pkg.sv
// Shared types and constants for the sample serializer: FSM encoding, frame geometry,
// parameter defaults and the saturating absolute-value helper used by the peak meter.
package sample_serializer_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int BITS_PER_FRAME = 32;
    localparam int BITS_PER_CH    = BITS_PER_FRAME / 2;
    localparam int BIT_CNT_W      = $clog2(BITS_PER_FRAME);

    localparam int FRAME_DIV_DEF  = 2083;
    localparam int BCLK_DIV_DEF   = 16;

    localparam logic [BIT_CNT_W-1:0] LAST_L_BIT = BIT_CNT_W'(BITS_PER_CH - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_R_BIT = BIT_CNT_W'(BITS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        SHIFT_L = 2'd2,
        SHIFT_R = 2'd3
    } ser_state_e;

    // Most negative sample has no positive twin; clamp it to full scale.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
        if (!s[SAMPLE_W-1])
            return s;
        if (s == {1'b1, {(SAMPLE_W-1){1'b0}}})
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        return -s;
    endfunction

endpackage

// File: rtl/sample_serializer_bit_clk_gen.sv
// bit_clk divider and falling-edge bit counter; idles low and cleared whenever en is 0.
// rise/fall are one-cycle strobes marking the clk edge on which bit_clk will toggle.
module bit_clk_gen
    import sample_serializer_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 bit_clk,
    output logic                 rise,
    output logic                 fall,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = en && (div_cnt == DIV_LAST);
    assign rise = tick && !bit_clk;
    assign fall = tick && bit_clk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_clk <= 1'b0;
            bit_cnt <= '0;
        end else if (!en) begin
            div_cnt <= '0;
            bit_clk <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                bit_clk <= ~bit_clk;
            if (fall)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sample_serializer.sv
// Frame-rate sample serializer: one captured sample sent MSB first as left then right.
// Define SAMPLE_SERIALIZER_PEAK_EN to build the peak-magnitude meter; otherwise peak is 0.
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEF,
    parameter int BCLK_DIV  = BCLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                new_frame,
    output logic                bit_clk,
    output logic                lrclk,
    output logic                sdata,
    input  logic                peak_clear,
    output logic [SAMPLE_W-1:0] peak
);

    if (2 * BITS_PER_FRAME * BCLK_DIV + 2 > FRAME_DIV) begin : g_cfg_check
        $error("sample_serializer: frame too short for 32 bits at this BCLK_DIV");
    end

    localparam int               CNT_W    = $clog2(FRAME_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0]     frame_cnt, frame_cnt_nxt;
    ser_state_e           state;
    logic [SAMPLE_W-1:0]  shreg;
    logic                 shifting, bclk_rise, bclk_fall;
    logic [BIT_CNT_W-1:0] bit_cnt;

    // Counter parks at 0 while disabled so a re-enable always starts a full frame.
    always_comb begin
        frame_cnt_nxt = '0;
        if (enable && frame_cnt != CNT_LAST)
            frame_cnt_nxt = frame_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            new_frame <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt_nxt;
            new_frame <= (frame_cnt_nxt == CNT_LAST);
        end
    end

    assign shifting = (state == SHIFT_L) || (state == SHIFT_R);

    bit_clk_gen #(.BCLK_DIV(BCLK_DIV)) u_bit_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .en      (shifting),
        .bit_clk (bit_clk),
        .rise    (bclk_rise),
        .fall    (bclk_fall),
        .bit_cnt (bit_cnt)
    );

    // shreg rotates once per sampled bit, so after 16 bits the MSB is back on top
    // for the right channel without reloading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
            lrclk <= 1'b0;
            sdata <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_frame)
                        state <= LOAD;
                end
                LOAD: begin
                    shreg <= sample_in;
                    sdata <= sample_in[SAMPLE_W-1];
                    state <= SHIFT_L;
                end
                SHIFT_L, SHIFT_R: begin
                    if (bclk_rise)
                        shreg <= {shreg[SAMPLE_W-2:0], shreg[SAMPLE_W-1]};
                    if (bclk_fall) begin
                        sdata <= shreg[SAMPLE_W-1];
                        if (state == SHIFT_L && bit_cnt == LAST_L_BIT) begin
                            state <= SHIFT_R;
                            lrclk <= 1'b1;
                        end else if (bit_cnt == LAST_R_BIT) begin
                            state <= IDLE;
                            lrclk <= 1'b0;
                            sdata <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SAMPLE_SERIALIZER_PEAK_EN
    logic [SAMPLE_W-1:0] peak_base, sample_abs;

    always_comb begin
        peak_base  = peak_clear ? '0 : peak;
        sample_abs = abs_sat(sample_in);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            peak <= '0;
        else if (state == LOAD)
            peak <= (sample_abs > peak_base) ? sample_abs : peak_base;
        else if (peak_clear)
            peak <= '0;
    end
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peak_clear;
    assign peak              = '0;
`endif

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer at FRAME_DIV=200, BCLK_DIV=2: stimulus queues
// expected strobe cycles and serial bits, a negedge monitor pops and compares them.
module tb_sample_serializer;

    localparam int FD = 200;
    localparam int BD = 2;

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, peak_clear = 1'b0;
    logic [15:0] sample_in = '0;
    logic        new_frame, bit_clk, lrclk, sdata;
    logic [15:0] peak;

    sample_serializer #(.FRAME_DIV(FD), .BCLK_DIV(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sample_in  (sample_in),
        .new_frame  (new_frame),
        .bit_clk    (bit_clk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .peak_clear (peak_clear),
        .peak       (peak)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        lr;
        logic        d;
        logic        first;
        logic [15:0] pk;
    } bit_exp_t;

    int       strobe_q[$];
    bit_exp_t bit_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void flag(string name, int at);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event at cycle %0d not expected", name, at);
    endfunction

    function automatic logic [15:0] pk_exp(logic [15:0] v);
`ifdef SAMPLE_SERIALIZER_PEAK_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    // Monitor: strobe timing/width, bits at each bit_clk rise, sdata stable while bit_clk high.
    logic prev_nf = 1'b0, prev_bclk = 1'b0, prev_sd = 1'b0;
    int   last_strobe = -1000;
    always @(negedge clk) begin
        bit_exp_t e;
        if (reset) begin
            if (new_frame) begin
                if (strobe_q.size() == 0) flag("unexpected_strobe", cyc);
                else check("strobe_cycle", cyc, strobe_q.pop_front());
                if (prev_nf) flag("strobe_width", cyc);
                last_strobe = cyc;
            end
            if (bit_clk && !prev_bclk) begin
                if (bit_q.size() == 0) flag("unexpected_bit", cyc);
                else begin
                    e = bit_q.pop_front();
                    check("lrclk", lrclk, e.lr);
                    check("sdata", sdata, e.d);
                    if (e.first) begin
                        check("first_rise_cycle", cyc, last_strobe + 2 + BD);
                        check("peak", peak, e.pk);
                    end
                end
            end
            if (sdata !== prev_sd && bit_clk) flag("sdata_change_while_bclk_high", cyc);
        end
        prev_nf   <= new_frame;
        prev_bclk <= bit_clk;
        prev_sd   <= sdata;
    end

    task automatic push_frame(input logic [15:0] pat, input logic [15:0] pk, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bit_exp_t e;
            e.lr    = (i >= 16);
            e.d     = pat[15 - (i % 16)];
            e.first = (i == 0);
            e.pk    = pk_exp(pk);
            bit_q.push_back(e);
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FD + 10; i++) begin
            @(negedge clk);
            if (new_frame) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("strobe_timeout", cyc);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_bit_clk"}, bit_clk, 1'b0);
        check({tag, "_lrclk"},   lrclk,   1'b0);
        check({tag, "_sdata"},   sdata,   1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  ok;

        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_new_frame", new_frame, 1'b0);
        check("reset_peak", peak, 16'h0000);

        // Continuous frames from reset release: strobes at 199, 399, 599, 799.
        reset  = 1'b1;
        enable = 1'b1;
        base   = cyc;
        for (int k = 1; k <= 4; k++) strobe_q.push_back(base + k * FD - 1);

        wait_strobe(ok);
        sample_in = 16'hA5C3;
        push_frame(16'b1010_0101_1100_0011, 16'h5A3D, 32);

        wait_strobe(ok);
        sample_in  = 16'h0100;
        peak_clear = 1'b1;
        push_frame(16'h0100, 16'h0100, 32);
        @(negedge clk);
        peak_clear = 1'b0;

        wait_strobe(ok);
        sample_in = 16'hFF00;
        push_frame(16'hFF00, 16'h0100, 32);

        wait_strobe(ok);
        sample_in = 16'h8000;
        push_frame(16'h8000, 16'h7FFF, 32);

        // Drop enable mid-frame: shift completes, no further strobe.
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        check_idle("disabled");
        check("disabled_bits_left", bit_q.size(), 0);
        repeat (150) @(negedge clk);

        enable = 1'b1;
        base   = cyc;
        strobe_q.push_back(base + FD - 1);
        strobe_q.push_back(base + 2 * FD - 1);

        // peak_clear coinciding with LOAD leaves only this sample's magnitude.
        wait_strobe(ok);
        sample_in = 16'h0010;
        push_frame(16'h0010, 16'h0010, 32);
        @(negedge clk);
        peak_clear = 1'b1;
        @(negedge clk);
        peak_clear = 1'b0;

        // Reset during bit 7 of the left channel.
        wait_strobe(ok);
        sample_in = 16'h1334;
        push_frame(16'h1334, 16'h1334, 8);
        repeat (33) @(negedge clk);
        #2;
        check("pre_reset_bit_clk", bit_clk, 1'b1);
        check("pre_reset_bits_left", bit_q.size(), 0);
        reset = 1'b0;
        #1;
        check_idle("async_reset");
        check("async_reset_new_frame", new_frame, 1'b0);
        check("async_reset_peak", peak, 16'h0000);
        repeat (3) @(negedge clk);

        reset = 1'b1;
        base  = cyc;
        strobe_q.push_back(base + FD - 1);
        wait_strobe(ok);
        sample_in = 16'h3C5A;
        push_frame(16'h3C5A, 16'h3C5A, 32);

        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bit_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("bits_timeout", cyc);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check_idle("final");
        check("final_strobes_left", strobe_q.size(), 0);
        repeat (250) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
